// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - OAM DMA sequencer: copies LEN bytes from a source page into OAM
// Optional build macro: OAM_DMA_SRC_REMAP_EN (latch echo-RAM pages 0xE0..0xFF as page-0x20)
module oam_dma_controller #(
    parameter int LEN         = 160,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [7:0]  trig_page,
    output logic [15:0] src_addr,
    output logic        src_rd,
    input  logic [7:0]  src_data,
    input  logic        ppu_oam_busy,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_wr,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        READ,
        CAPTURE,
        WRITE
    } state_t;

    localparam logic [7:0] LAST_IDX    = 8'(LEN - 1);
    localparam logic [3:0] DLY_INIT    = 4'(START_DELAY);
    localparam state_t     START_STATE = (START_DELAY > 0) ? DELAY : READ;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [3:0]  dly;
    logic [7:0]  wdata;
    logic [7:0]  page_in;
    logic        last_byte;

`ifdef OAM_DMA_SRC_REMAP_EN
    // Echo-RAM source pages alias onto work RAM 0x2000 below.
    assign page_in = (trig_page >= 8'hE0) ? (trig_page - 8'h20) : trig_page;
`else
    assign page_in = trig_page;
`endif

    assign last_byte = (idx == LAST_IDX);

    assign busy      = (state != IDLE);
    assign src_rd    = (state == READ);
    assign src_addr  = src_rd ? {page, idx} : 16'h0000;
    assign oam_addr  = idx;
    assign oam_wdata = wdata;

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and OAM write strobe; a trigger restarts from any state.
    always_comb begin
        state_nxt = state;
        oam_wr    = 1'b0;
        case (state)
            IDLE:    state_nxt = IDLE;
            DELAY:   if (dly == 4'd1) state_nxt = READ;
            READ:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = WRITE;
            WRITE: begin
                if (!ppu_oam_busy) begin
                    oam_wr    = 1'b1;
                    state_nxt = last_byte ? IDLE : READ;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (trig) begin
            state_nxt = START_STATE;
        end
    end

    // Transfer datapath: page/index/delay/data registers and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page  <= 8'h00;
            idx   <= 8'h00;
            dly   <= 4'h0;
            wdata <= 8'h00;
            done  <= 1'b0;
        end else begin
            // A restart on the final write cancels that transfer's done pulse.
            done <= oam_wr && last_byte && !trig;
            if (trig) begin
                page <= page_in;
                idx  <= 8'h00;
                dly  <= DLY_INIT;
            end else begin
                if (state == DELAY) begin
                    dly <= dly - 4'd1;
                end
                if (state == CAPTURE) begin
                    wdata <= src_data;
                end
                if (oam_wr && !last_byte) begin
                    idx <= idx + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb/tb_oam_dma_controller.sv - randomized self-checking bench for oam_dma_controller
module tb_oam_dma_controller;

    localparam int LEN   = 160;
    localparam int SD    = 1;
    localparam int BIG   = 1 << 30;
    localparam int DEPTH = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig = 1'b0;
    logic [7:0]  trig_page = 8'h00;
    logic [15:0] src_addr;
    logic        src_rd;
    logic [7:0]  src_data = 8'h00;
    logic        ppu_oam_busy = 1'b0;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_wr;
    logic        busy;
    logic        done;

    logic        s_trig = 1'b0;
    logic [7:0]  s_trig_page = 8'h12;
    logic [15:0] s_src_addr;
    logic        s_src_rd;
    logic [7:0]  s_src_data = 8'hA7;
    logic        s_ppu_oam_busy = 1'b0;
    logic [7:0]  s_oam_addr;
    logic [7:0]  s_oam_wdata;
    logic        s_oam_wr;
    logic        s_busy;
    logic        s_done;

    oam_dma_controller #(.LEN(LEN), .START_DELAY(SD)) dut (
        .clk(clk), .rst(rst), .trig(trig), .trig_page(trig_page),
        .src_addr(src_addr), .src_rd(src_rd), .src_data(src_data),
        .ppu_oam_busy(ppu_oam_busy), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
        .oam_wr(oam_wr), .busy(busy), .done(done)
    );

    oam_dma_controller #(.LEN(1), .START_DELAY(0)) dut_short (
        .clk(clk), .rst(rst), .trig(s_trig), .trig_page(s_trig_page),
        .src_addr(s_src_addr), .src_rd(s_src_rd), .src_data(s_src_data),
        .ppu_oam_busy(s_ppu_oam_busy), .oam_addr(s_oam_addr), .oam_wdata(s_oam_wdata),
        .oam_wr(s_oam_wr), .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          c;
        logic [15:0] a;
        logic [7:0]  d;
    } ev_t;

    ev_t exp_wr[$];
    ev_t act_wr[$];
    ev_t exp_rd[$];
    ev_t act_rd[$];
    int  exp_done[$];
    int  act_done[$];
    bit  stall_map [DEPTH];
    bit  exp_busy  [DEPTH];

    // PPU ownership follows a per-cycle map shared with the reference model.
    always @(posedge clk) begin
        #1;
        ppu_oam_busy = (cyc < DEPTH) ? stall_map[cyc] : 1'b0;
    end

    // Source memory: byte = lo ^ hi ^ 0x5A, returned the cycle after the read; noise otherwise.
    logic       pend = 1'b0;
    logic [7:0] pend_val = 8'h00;
    always @(negedge clk) begin
        src_data = pend ? pend_val : 8'($urandom);
        pend     = src_rd;
        pend_val = src_addr[7:0] ^ src_addr[15:8] ^ 8'h5A;
    end

    // Event recorder plus per-cycle busy and idle-address checks.
    always @(negedge clk) begin
        if (oam_wr) act_wr.push_back('{cyc, {8'h00, oam_addr}, oam_wdata});
        if (src_rd) act_rd.push_back('{cyc, src_addr, 8'h00});
        else        check_eq("src_addr_idle", src_addr, 32'h0);
        if (done)   act_done.push_back(cyc);
        check_eq("busy", busy, (cyc < DEPTH) ? exp_busy[cyc] : 1'b0);
    end

    function automatic logic [7:0] remap(input logic [7:0] p);
`ifdef OAM_DMA_SRC_REMAP_EN
        return (p >= 8'hE0) ? p - 8'h20 : p;
`else
        return p;
`endif
    endfunction

    // Schedule: read, capture, write per byte; PPU stalls push the write later; events after cut vanish.
    task automatic model_xfer(input int t0, input logic [7:0] tp, input int cut, output int last_wr);
        int t;
        int busy_end;
        logic [7:0] pg;
        pg = remap(tp);
        t = t0 + SD + 1;
        last_wr = t0;
        for (int k = 0; k < LEN; k++) begin
            if (t <= cut) exp_rd.push_back('{t, {pg, 8'(k)}, 8'h00});
            t += 2;
            while (stall_map[t]) t++;
            if (t <= cut) exp_wr.push_back('{t, 16'(k), 8'(k) ^ pg ^ 8'h5A});
            last_wr = t;
            t++;
        end
        if (last_wr < cut) exp_done.push_back(last_wr + 1);
        busy_end = (last_wr < cut) ? last_wr : cut;
        for (int c = t0 + 1; c <= busy_end; c++) exp_busy[c] = 1'b1;
    endtask

    task automatic compare_events();
        check_eq("wr_count", act_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++) begin
            check_eq("wr_cycle", act_wr[i].c, exp_wr[i].c);
            check_eq("wr_idx",   act_wr[i].a, exp_wr[i].a);
            check_eq("wr_data",  act_wr[i].d, exp_wr[i].d);
        end
        check_eq("rd_count", act_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < act_rd.size(); i++) begin
            check_eq("rd_cycle", act_rd[i].c, exp_rd[i].c);
            check_eq("rd_addr",  act_rd[i].a, exp_rd[i].a);
        end
        check_eq("done_count", act_done.size(), exp_done.size());
        for (int i = 0; i < exp_done.size() && i < act_done.size(); i++)
            check_eq("done_cycle", act_done[i], exp_done[i]);
        exp_wr.delete(); act_wr.delete();
        exp_rd.delete(); act_rd.delete();
        exp_done.delete(); act_done.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic fire(input logic [7:0] p);
        trig = 1'b1;
        trig_page = p;
        step();
        trig = 1'b0;
        trig_page = 8'($urandom);
    endtask

    function automatic int last_wr_cycle();
        return (act_wr.size() > 0) ? act_wr[act_wr.size() - 1].c : -1;
    endfunction

    int t0, t1, r, lw, lw2;
    logic [7:0] p;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",     busy,     32'h0);
        check_eq("rst_oam_wr",   oam_wr,   32'h0);
        check_eq("rst_src_rd",   src_rd,   32'h0);
        check_eq("rst_done",     done,     32'h0);
        check_eq("rst_src_addr", src_addr, 32'h0);
        check_eq("rst_oam_addr", oam_addr, 32'h0);
        rst = 1'b0;
        step();

        // Basic transfer from page 0xC1, no stalls.
        t0 = cyc;
        model_xfer(t0, 8'hC1, BIG, lw);
        fire(8'hC1);
        wait_to(lw + 4);
        check_eq("first_src_addr", (act_rd.size() > 0) ? act_rd[0].a : 16'hFFFF, 16'hC100);
        check_eq("last_wr_latency", last_wr_cycle() - t0, 481);
        check_eq("done_latency", (act_done.size() > 0) ? act_done[0] - t0 : -1, 482);
        compare_events();

        // Five-cycle PPU hold on the write of index 0x10.
        t0 = cyc;
        for (int c = 0; c < 5; c++) stall_map[t0 + SD + 3 + 3 * 16 + c] = 1'b1;
        model_xfer(t0, 8'h3C, BIG, lw);
        fire(8'h3C);
        wait_to(lw + 4);
        check_eq("stall_latency", last_wr_cycle() - t0, 486);
        compare_events();

        // Restart at index 0x40: page 0x80 then 0xC0.
        t0 = cyc;
        t1 = t0 + SD + 1 + 3 * 8'h40;
        model_xfer(t0, 8'h80, t1, lw);
        model_xfer(t1, 8'hC0, BIG, lw2);
        fire(8'h80);
        wait_to(t1);
        fire(8'hC0);
        wait_to(lw2 + 4);
        check_eq("restart_done_pulses", act_done.size(), 1);
        compare_events();

        // Reset while capturing index 0x22, then a fresh transfer.
        t0 = cyc;
        r = t0 + SD + 2 + 3 * 8'h22;
        model_xfer(t0, 8'h55, r - 1, lw);
        fire(8'h55);
        wait_to(r);
        rst = 1'b1;
        #1;
        check_eq("midrst_busy",   busy,   32'h0);
        check_eq("midrst_oam_wr", oam_wr, 32'h0);
        check_eq("midrst_src_rd", src_rd, 32'h0);
        check_eq("midrst_done",   done,   32'h0);
        step();
        step();
        rst = 1'b0;
        step();
        compare_events();
        t0 = cyc;
        p = 8'($urandom);
        model_xfer(t0, p, BIG, lw);
        fire(p);
        wait_to(lw + 4);
        compare_events();

        // Echo-RAM page.
        t0 = cyc;
        model_xfer(t0, 8'hFE, BIG, lw);
        fire(8'hFE);
        wait_to(lw + 4);
`ifdef OAM_DMA_SRC_REMAP_EN
        check_eq("fe_page", (act_rd.size() > 0) ? act_rd[0].a[15:8] : 8'h00, 8'hDE);
`else
        check_eq("fe_page", (act_rd.size() > 0) ? act_rd[0].a[15:8] : 8'h00, 8'hFE);
`endif
        compare_events();

        // Random pages with random PPU ownership.
        for (int n = 0; n < 3; n++) begin
            t0 = cyc;
            for (int c = t0; c < t0 + 1200; c++) stall_map[c] = ($urandom_range(0, 9) == 0);
            p = 8'($urandom);
            model_xfer(t0, p, BIG, lw);
            fire(p);
            wait_to(lw + 4);
            compare_events();
        end

        // Single-byte build with no start delay.
        s_trig = 1'b1;
        step();
        s_trig = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check_eq("short_src_rd", s_src_rd, (i == 1));
            check_eq("short_oam_wr", s_oam_wr, (i == 3));
            check_eq("short_done",   s_done,   (i == 4));
            check_eq("short_busy",   s_busy,   (i <= 3));
            if (i == 1) check_eq("short_src_addr", s_src_addr, 16'h1200);
            if (i == 3) begin
                check_eq("short_oam_addr",  s_oam_addr,  8'h00);
                check_eq("short_oam_wdata", s_oam_wdata, 8'hA7);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Sequences the 160-byte OAM DMA transfer started by a CPU write to 0xFF46. It replaces the ad-hoc DMA state machine inside the memory unit.
- Reads bytes from a source page through the banked-SRAM DMA read port and writes them to OAM index 0x00..LEN-1 through the OAM DMA write port.
- Yields each OAM write cycle to the PPU when the PPU owns OAM.
- Exports busy so the CPU path can restrict itself to HRAM during a transfer.

Parameters:
- LEN, 160, number of bytes per transfer (1..256).
- START_DELAY, 1, idle cycles between trigger and first source read (0..15).

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- trig  input  1  one-cycle pulse: CPU wrote register 0xFF46
- trig_page  input  8  value written to 0xFF46 (source high byte); sampled when trig=1
- src_addr  output  16  source read address, {page, idx}
- src_rd  output  1  source read strobe; data is returned 1 cycle later
- src_data  input  8  source read data; valid the cycle after src_rd
- ppu_oam_busy  input  1  PPU owns OAM this cycle; DMA must not write
- oam_addr  output  8  OAM write index
- oam_wdata  output  8  OAM write data
- oam_wr  output  1  OAM write strobe
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse after the last byte is written

Behaviour:
- Registers:
  - page[7:0]
  - idx[7:0]
  - dly[3:0]
  - wdata[7:0]
  - state in {IDLE, DELAY, READ, CAPTURE, WRITE}
- Reset values: state=IDLE; idx=0; page=0; all outputs 0; src_addr=0.
- Reset mid-transfer aborts immediately. No done pulse is produced, and OAM keeps any partially written bytes.
- Output decoding:
  - busy=1 in every state except IDLE.
  - src_rd=1 only in READ.
  - src_addr={page, idx} in READ, 0 otherwise.
  - oam_addr=idx.
  - oam_wdata=wdata.
  - oam_wr=(state==WRITE) and not ppu_oam_busy. This is combinational on ppu_oam_busy.
- IDLE:
  - On trig: page<=trig_page, idx<=0, dly<=START_DELAY.
  - Next state is DELAY if START_DELAY>0, else READ.
- DELAY: dly decrements each cycle; when dly==1 the next state is READ.
- READ: src_rd asserted; next state is CAPTURE.
- CAPTURE: wdata<=src_data; next state is WRITE.
- WRITE:
  - If ppu_oam_busy: stay in WRITE with oam_wr=0. There is no stall limit.
  - Else, oam_wr=1 this cycle, then:
    - if idx==LEN-1, the next state is IDLE and done=1 on the following cycle (registered);
    - otherwise idx<=idx+1 and the next state is READ.
- Throughput is 3 cycles per byte with no stalls. A transfer with no stalls takes START_DELAY+3*LEN cycles from trig to the last oam_wr; done follows 1 cycle later.
- idx is compared with an 8-bit equality to LEN-1. idx never wraps.
- trig while busy (any state other than IDLE), including the final WRITE cycle:
  - Restart: page<=trig_page, idx<=0, dly reload, go to DELAY/READ.
  - Any oam_wr in that same cycle still occurs.
  - done is suppressed for the aborted transfer, and busy stays 1.
- The block never touches the 0xFF46 register contents; the register bank holds them.

Optional Feature:
- Macro: OAM_DMA_SRC_REMAP_EN.
- Defined: when trig_page is 0xE0..0xFF, page is latched as trig_page-0x20 (echo-RAM alias, so 0xFE becomes 0xDE). Other pages are latched unchanged.
- Undefined: page is latched verbatim for all values, and no subtractor is synthesized.

Test Plan:
- Reset, then trig with trig_page=0xC1, START_DELAY=1, LEN=160, ppu_oam_busy=0, and the source model returning (addr[7:0]^0x5A):
  - busy rises the cycle after trig;
  - first src_addr=0xC100;
  - oam_wr at indices 0x00..0x9F with data idx^0x5A;
  - last oam_wr occurs 481 cycles after trig, and done pulses 1 cycle later;
  - busy=0 on the cycle after done.
- Assert ppu_oam_busy for 5 cycles while the block is in WRITE at idx=0x10 -> oam_wr stays 0 during those 5 cycles, the byte at 0x10 is written once after release, and total duration grows by exactly 5 cycles.
- trig with page 0x80 and, at idx=0x40, trig again with page 0xC0 -> idx returns to 0 and src_addr=0xC000 on the next READ. Exactly one done pulse occurs, at the end of the second transfer.
- Assert rst while the block is in CAPTURE at idx=0x22 -> busy, oam_wr, src_rd and done are all 0 during reset. A later trig starts at idx 0.
- trig_page=0xFE -> src_addr high byte is 0xDE with OAM_DMA_SRC_REMAP_EN defined, and 0xFE without it.
- Build with LEN=1 and START_DELAY=0 -> READ in the cycle after trig, exactly one oam_wr to index 0 at cycle 3, and done at cycle 4.
